// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32 subset core (lw/sw/add/sub/and/or/slt/addi/beq/jal) on one shared memory port.
// Define RISCV_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module riscv_multicycle_core #(
  parameter int unsigned           WORD_WIDTH     = 32,
  parameter int unsigned           REG_ADDR_WIDTH = 5,
  parameter logic [WORD_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned           CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [WORD_WIDTH-1:0]     mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready,
  output logic [WORD_WIDTH-1:0]     pc,
  output logic [2:0]                state,
  output logic                      rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WORD_WIDTH-1:0]     rf_wr_data,
  output logic                      instr_retired,
  output logic                      halted
`ifdef RISCV_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      instret_cnt
`endif
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [WORD_WIDTH-1:0]   alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]             ir_q, ir_d;
  logic                    halted_q, halted_d;
  logic [WORD_WIDTH-1:0]   regs_q [NumRegs];
  logic [WORD_WIDTH-1:0]   regs_d [NumRegs];

  logic [6:0]              opcode, funct7;
  logic [2:0]              funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                    is_lw, is_sw, is_r, is_addi, is_beq, is_jal, legal;
  logic [WORD_WIDTH-1:0]   rs1_val, rs2_val, imm_sel, alu_res;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rd      = ir_q[7 +: REG_ADDR_WIDTH];
  assign rs1     = ir_q[15 +: REG_ADDR_WIDTH];
  assign rs2     = ir_q[20 +: REG_ADDR_WIDTH];
  assign is_lw   = (opcode == 7'h03) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'h23) && (funct3 == 3'b010);
  assign is_addi = (opcode == 7'h13) && (funct3 == 3'b000);
  assign is_beq  = (opcode == 7'h63) && (funct3 == 3'b000);
  assign is_jal  = (opcode == 7'h6f);
  assign is_r    = (opcode == 7'h33) &&
                   (((funct7 == 7'h00) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                    ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign legal   = is_lw | is_sw | is_addi | is_beq | is_jal | is_r;

  assign rs1_val = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs_q[rs2];

  always_comb begin
    if (is_sw) begin
      imm_sel = WORD_WIDTH'($signed({ir_q[31:25], ir_q[11:7]}));
    end else if (is_beq) begin
      imm_sel = WORD_WIDTH'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    end else if (is_jal) begin
      imm_sel = WORD_WIDTH'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
    end else begin
      imm_sel = WORD_WIDTH'($signed(ir_q[31:20]));
    end
  end

  // jal reuses the ALU result register to carry the link address into WB.
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_jal) begin
      alu_res = pc_q + WORD_WIDTH'(4);
    end else if (is_r) begin
      unique case (funct3)
        3'b000:  alu_res = funct7[5] ? (a_q - b_q) : (a_q + b_q);
        3'b111:  alu_res = a_q & b_q;
        3'b110:  alu_res = a_q | b_q;
        3'b010:  alu_res = WORD_WIDTH'($signed(a_q) < $signed(b_q));
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    imm_d         = imm_q;
    alu_d         = alu_q;
    mdr_d         = mdr_q;
    halted_d      = halted_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = alu_q;
    mem_wdata     = b_q;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = rd;
    rf_wr_data    = is_lw ? mdr_q : alu_q;
    instr_retired = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = rs1_val;
        b_d   = rs2_val;
        imm_d = imm_sel;
        if (legal) begin
          state_d = StExec;
        end else begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end
      end
      StExec: begin
        if (is_beq) begin
          pc_d          = (a_q == b_q) ? (pc_q + imm_q) : (pc_q + WORD_WIDTH'(4));
          instr_retired = 1'b1;
          state_d       = StFetch;
        end else begin
          alu_d   = alu_res;
          state_d = (is_lw || is_sw) ? StMem : StWb;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_d          = pc_q + WORD_WIDTH'(4);
            instr_retired = 1'b1;
            state_d       = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_wr_en      = (rd != '0);
        instr_retired = 1'b1;
        pc_d          = is_jal ? (pc_q + imm_q) : (pc_q + WORD_WIDTH'(4));
        state_d       = StFetch;
      end
      StHalt: ;
      default: begin
        state_d  = StHalt;
        halted_d = 1'b1;
      end
    endcase
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      rf_wr_en      = 1'b0;
      instr_retired = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (rf_wr_en) begin
      regs_d[rf_wr_addr] = rf_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
    end
  end

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = halted_q;

`ifdef RISCV_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != StHalt) begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    end
    if (instr_retired) begin
      instret_cnt_d = instret_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: small programs with hand-computed register/PC results.
module tb_riscv_multicycle_core;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        instr_retired, halted;
`ifdef RISCV_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  logic [31:0] imem [64];
  logic [31:0] dmem_word;
  int          stall_cnt = 3;
  int          we_cycles = 0;
  int          writes = 0;
  int          hold_bad = 0;
  int          rf_wr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  riscv_multicycle_core #(
    .WORD_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .RESET_PC      (32'h0),
    .CNT_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc           (pc),
    .state        (state),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .instr_retired(instr_retired),
    .halted       (halted)
`ifdef RISCV_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetches come from imem, data reads return dmem_word; only the store sees wait states.
  always_comb mem_rdata = (state == 3'd0) ? imem[mem_addr[7:2]] : dmem_word;
  always_comb mem_ready = !(mem_req && mem_we && stall_cnt != 0);

  always @(posedge clk) begin
    if (mem_req && mem_we && stall_cnt != 0) stall_cnt <= stall_cnt - 1;
  end

  always @(negedge clk) begin
    if (mem_req && mem_we) begin
      we_cycles++;
      if (mem_addr != 32'h8 || mem_wdata != 32'd10) hold_bad++;
      if (mem_ready) writes++;
    end
    if (rf_wr_en) rf_wr_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH to its retire edge and checks length, rf write and new PC.
  task automatic run_instr(input string tag, input int exp_cyc, input logic exp_we,
                           input logic [4:0] exp_wa, input logic [31:0] exp_wd,
                           input logic [31:0] exp_pc);
    int          cyc = 1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    while (!instr_retired && cyc < 40) begin
      step();
      cyc++;
    end
    we = rf_wr_en;
    wa = rf_wr_addr;
    wd = rf_wr_data;
    step();
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
    check_eq({tag, "_wr_en"}, {31'd0, we}, {31'd0, exp_we});
    if (exp_we) begin
      check_eq({tag, "_wr_addr"}, {27'd0, wa}, {27'd0, exp_wa});
      check_eq({tag, "_wr_data"}, wd, exp_wd);
    end
    check_eq({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    int wr_before;
    int bad;
    rst       = 1'b1;
    dmem_word = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0] = 32'h00500093;  // addi x1,x0,5
    imem[1] = 32'h00108133;  // add  x2,x1,x1
    imem[2] = 32'h00202423;  // sw   x2,8(x0)
    imem[3] = 32'h00802183;  // lw   x3,8(x0)
    imem[4] = 32'hFE000EE3;  // beq  x0,x0,-4

    step();
    check_eq("rst_req_c1", {31'd0, mem_req}, 32'd0);
    check_eq("rst_retire_c1", {31'd0, instr_retired}, 32'd0);
    step();
    check_eq("rst_req_c2", {31'd0, mem_req}, 32'd0);
    check_eq("rst_wr_en_c2", {31'd0, rf_wr_en}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req", {31'd0, mem_req}, 32'd1);
    check_eq("post_rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("post_rst_addr", mem_addr, 32'h0);
    check_eq("post_rst_state", {29'd0, state}, 32'd0);
    check_eq("post_rst_halted", {31'd0, halted}, 32'd0);

    run_instr("addi", 4, 1'b1, 5'd1, 32'd5, 32'h4);
    run_instr("add", 4, 1'b1, 5'd2, 32'd10, 32'h8);
    run_instr("sw", 7, 1'b0, 5'd0, 32'd0, 32'hC);
    check_eq("sw_req_cycles", we_cycles, 32'd4);
    check_eq("sw_writes", writes, 32'd1);
    check_eq("sw_hold_unstable", hold_bad, 32'd0);

    dmem_word = 32'hDEADBEEF;
    run_instr("lw", 5, 1'b1, 5'd3, 32'hDEADBEEF, 32'h10);
    run_instr("beq", 3, 1'b0, 5'd0, 32'd0, 32'hC);

    // Re-fetch the lw and abort it with reset while it sits in MEM.
    wr_before = rf_wr_cnt;
    step();
    step();
    step();
    check_eq("lw2_in_mem", {29'd0, state}, 32'd3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
    step();
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_state", {29'd0, state}, 32'd0);
    check_eq("mid_rst_no_rf_wr", rf_wr_cnt, wr_before);

    imem[0] = 32'hFFD00093;  // addi x1,x0,-3
    imem[1] = 32'h00600113;  // addi x2,x0,6
    imem[2] = 32'h402081B3;  // sub  x3,x1,x2
    imem[3] = 32'h0020A233;  // slt  x4,x1,x2
    imem[4] = 32'h0020F2B3;  // and  x5,x1,x2
    imem[5] = 32'h0020E333;  // or   x6,x1,x2
    imem[6] = 32'h008003EF;  // jal  x7,+8
    imem[7] = 32'hFFFFFFFF;  // skipped by jal
    imem[8] = 32'h00208033;  // add  x0,x1,x2
    imem[9] = 32'hFFFFFFFF;  // illegal
    step();
    rst = 1'b0;

    run_instr("addi_neg", 4, 1'b1, 5'd1, 32'hFFFFFFFD, 32'h4);
    run_instr("addi_pos", 4, 1'b1, 5'd2, 32'd6, 32'h8);
    run_instr("sub", 4, 1'b1, 5'd3, 32'hFFFFFFF7, 32'hC);
    run_instr("slt", 4, 1'b1, 5'd4, 32'd1, 32'h10);
    run_instr("and", 4, 1'b1, 5'd5, 32'd4, 32'h14);
    run_instr("or", 4, 1'b1, 5'd6, 32'hFFFFFFFF, 32'h18);
    run_instr("jal", 4, 1'b1, 5'd7, 32'h1C, 32'h20);
    wr_before = rf_wr_cnt;
    run_instr("add_x0", 4, 1'b0, 5'd0, 32'd0, 32'h24);
    check_eq("add_x0_no_rf_wr", rf_wr_cnt, wr_before);

    step();
    check_eq("ill_decode", {29'd0, state}, 32'd1);
    step();
    check_eq("ill_state", {29'd0, state}, 32'd7);
    check_eq("ill_halted", {31'd0, halted}, 32'd1);
    check_eq("ill_req", {31'd0, mem_req}, 32'd0);
    check_eq("ill_pc", pc, 32'h24);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req || instr_retired || !halted || pc != 32'h24 || state != 3'd7) bad++;
    end
    check_eq("halt_stuck_cycles", bad, 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("unhalt_halted", {31'd0, halted}, 32'd0);
    check_eq("unhalt_state", {29'd0, state}, 32'd0);
    check_eq("unhalt_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
